alu_checker: RTL and testbench
==============================

# alu_checker

Synthesizable result checker for the 2-bit-opcode 8-bit ALU (add, multiply, decrement, transfer). It receives one (opcode, a, b, y) observation per handshake, recomputes the expected 16-bit result in a two-stage pipeline, and keeps saturating per-opcode error counters, a sample counter and a capture of the first mismatch. It sits beside the ALU on FPGA builds as the receiving end of the stimulus/response stream, replacing the software comparison done in simulation.

## Interface
- CNT_W, 8, width of each per-opcode error counter
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  observation present on opcode/a/b/y
- in_ready  output  1  checker accepts observation this cycle
- opcode  input  2  0 add, 1 mul, 2 dec, 3 transfer
- a, b  input  8 each  ALU operands
- y  input  16  ALU result under test
- clear  input  1  synchronous clear of all statistics and pipeline
- err_add, err_mul, err_dec, err_mov  output  CNT_W each  mismatch counts per opcode
- sample_count  output  16  accepted observations that completed checking
- err_flag  output  1  sticky: any mismatch since reset/clear
- first_valid  output  1  first-error capture is valid
- first_opcode / first_a / first_b / first_y  output  2/8/8/16  first mismatching observation

## Operation
- Accept when in_valid && in_ready on a rising edge; otherwise inputs ignored.
- Expected value, all 16-bit unsigned: op0 {8'h00,a}+{8'h00,b} (max 16'h01FE); op1 a*b (max 16'hFE01); op2 ({8'h00,a}-1) mod 2^16, so a=0 expects 16'hFFFF; op3 {8'h00,b} (a ignored).
- Stage 1: register observation + valid. Stage 2: register expected value and mismatch = (y != expected). Update: on the edge after stage 2, sample_count+1; on mismatch, the opcode's counter +1, err_flag<=1, and if first_valid==0 capture opcode/a/b/y and set first_valid.
- All counters saturate at all-ones (no wrap).
- State machine: RUN, HALT (HALT reachable only with macro, see Configuration). RUN->HALT on a mismatch update; HALT->RUN only on clear.
- clear: zeroes counters, err_flag, first_* outputs, flushes both stages (in-flight observations not counted), state->RUN. in_ready is 0 while clear is 1; clear wins over any simultaneous update.
- in_ready = !clear && state==RUN (plus the halt rule below).
- Reset: all counters 0, err_flag 0, first_valid 0, first_* 0, stage valids 0, state RUN; in_ready 0 while rst high, 1 the first cycle after.

## Timing
- Observation accepted at edge N: stage 1 at N, stage 2 at N+1, outputs updated after edge N+2 (latency 2 cycles).
- Full throughput: one observation per cycle, no bubbles in RUN.
- Reset asserted mid-stream discards all in-flight observations; nothing counted.
- clear at edge M: observations accepted at edges M-1 and M-2 are discarded; counts after M are 0.

## Configuration
- ALU_CHECKER_HALT_EN defined: first mismatch at update moves state to HALT; in_ready additionally 0 while stage 2 holds a valid mismatch; the observation sitting in stage 1 at that time is discarded, not counted; statistics frozen until clear.
- Not defined: HALT unreachable; checker keeps running and counting after mismatches; in_ready = !clear outside reset.

## Test plan
- 20 correct adds (incl. a=255,b=255,y=16'h01FE), in_valid held high -> sample_count=20, all err_* 0, err_flag 0, in_ready constant 1.
- op2 a=0 y=16'hFFFF, then op1 a=200 b=150 y=16'h7530 -> no errors; op3 a=9 b=77 y=16'h0004 -> err_mov=1, first_opcode=3, first_y=16'h0004, visible 2 cycles after acceptance.
- Two mismatches (op1 then op0) without macro -> err_mul=1, err_add=1, first capture holds op1 values; with macro -> in_ready drops, err_mul=1, err_add=0, follower discarded, recover only after clear.
- CNT_W=2, 5 wrong adds without macro -> err_add=3 (saturated), sample_count=5.
- clear pulsed same cycle as in_valid with two observations in flight -> that observation not accepted, all counters 0, first_valid 0 afterwards; rst mid-stream likewise leaves all outputs 0.

Source files
------------

// File: rtl/alu_checker.sv
// Result checker for the 2-bit-opcode 8-bit ALU: two-stage recompute pipeline, saturating error statistics and first-mismatch capture.
// Optional build macro ALU_CHECKER_HALT_EN: stop accepting and freeze statistics at the first mismatch until clear.
module alu_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       opcode,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic [15:0]      y,
    input  logic             clear,
    output logic [CNT_W-1:0] err_add,
    output logic [CNT_W-1:0] err_mul,
    output logic [CNT_W-1:0] err_dec,
    output logic [CNT_W-1:0] err_mov,
    output logic [15:0]      sample_count,
    output logic             err_flag,
    output logic             first_valid,
    output logic [1:0]       first_opcode,
    output logic [7:0]       first_a,
    output logic [7:0]       first_b,
    output logic [15:0]      first_y
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        upd_en;

    logic        vld_p1;
    logic [1:0]  op_p1;
    logic [7:0]  a_p1, b_p1;
    logic [15:0] y_p1;

    logic        vld_p2;
    logic        mis_p2;
    logic [1:0]  op_p2;
    logic [7:0]  a_p2, b_p2;
    logic [15:0] y_p2;

    function automatic logic [15:0] expected_result(input logic [1:0] op,
                                                    input logic [7:0] a_v,
                                                    input logic [7:0] b_v);
        case (op)
            2'd0:    return {8'h00, a_v} + {8'h00, b_v};
            2'd1:    return {8'h00, a_v} * {8'h00, b_v};
            2'd2:    return {8'h00, a_v} - 16'd1;
            default: return {8'h00, b_v};
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc_16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    assign accept = in_valid && in_ready;
    // Statistics are frozen outside RUN, which also drops the stage-1 follower of a halting mismatch.
    assign upd_en = vld_p2 && (state == RUN);

    always_comb begin
        in_ready = !rst && !clear && (state == RUN);
`ifdef ALU_CHECKER_HALT_EN
        if (vld_p2 && mis_p2)
            in_ready = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = RUN;
`ifdef ALU_CHECKER_HALT_EN
        else if (upd_en && mis_p2)
            state_nxt = HALT;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Stage 1: register the accepted observation
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= accept && !clear;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1 <= opcode;
            a_p1  <= a;
            b_p1  <= b;
            y_p1  <= y;
        end
    end

    // Stage 2: recompute expected result and compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p2 <= 1'b0;
        else
            vld_p2 <= vld_p1 && !clear;
    end

    always_ff @(posedge clk) begin
        if (vld_p1) begin
            op_p2  <= op_p1;
            a_p2   <= a_p1;
            b_p2   <= b_p1;
            y_p2   <= y_p1;
            mis_p2 <= (y_p1 != expected_result(op_p1, a_p1, b_p1));
        end
    end

    // Update: statistics and first-mismatch capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            err_add      <= '0;
            err_mul      <= '0;
            err_dec      <= '0;
            err_mov      <= '0;
            sample_count <= '0;
            err_flag     <= 1'b0;
            first_valid  <= 1'b0;
            first_opcode <= '0;
            first_a      <= '0;
            first_b      <= '0;
            first_y      <= '0;
        end else if (upd_en) begin
            sample_count <= sat_inc_16(sample_count);
            if (mis_p2) begin
                case (op_p2)
                    2'd0:    err_add <= sat_inc_cnt(err_add);
                    2'd1:    err_mul <= sat_inc_cnt(err_mul);
                    2'd2:    err_dec <= sat_inc_cnt(err_dec);
                    default: err_mov <= sat_inc_cnt(err_mov);
                endcase
                err_flag <= 1'b1;
                if (!first_valid) begin
                    first_valid  <= 1'b1;
                    first_opcode <= op_p2;
                    first_a      <= a_p2;
                    first_b      <= b_p2;
                    first_y      <= y_p2;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_checker.sv
// Randomized self-checking bench for alu_checker against a transaction-level reference model.
// Expectations follow ALU_CHECKER_HALT_EN when the bench is built with that macro.
module tb_alu_checker;

    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       opcode = '0;
    logic [7:0]       a = '0;
    logic [7:0]       b = '0;
    logic [15:0]      y = '0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] err_add, err_mul, err_dec, err_mov;
    logic [15:0]      sample_count;
    logic             err_flag, first_valid;
    logic [1:0]       first_opcode;
    logic [7:0]       first_a, first_b;
    logic [15:0]      first_y;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_err[4];
    int          m_samples;
    bit          m_flag, m_first_valid, m_halt;
    logic [1:0]  m_first_op;
    logic [7:0]  m_first_a, m_first_b;
    logic [15:0] m_first_y;

    alu_checker #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .y(y), .clear(clear),
        .err_add(err_add), .err_mul(err_mul), .err_dec(err_dec), .err_mov(err_mov),
        .sample_count(sample_count), .err_flag(err_flag), .first_valid(first_valid),
        .first_opcode(first_opcode), .first_a(first_a), .first_b(first_b), .first_y(first_y)
    );

    always #5 clk = ~clk;

    function automatic int ref_result(input int op, input int av, input int bv);
        case (op)
            0:       return av + bv;
            1:       return av * bv;
            2:       return (av + 65535) % 65536;
            default: return bv;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_err[i] = 0;
        m_samples = 0; m_flag = 0; m_first_valid = 0; m_halt = 0;
        m_first_op = '0; m_first_a = '0; m_first_b = '0; m_first_y = '0;
    endtask

    task automatic model_apply(input int op, input int av, input int bv, input int yv);
        if (m_halt) return;
        if (m_samples < 65535) m_samples++;
        if (yv != ref_result(op, av, bv)) begin
            if (m_err[op] < CNT_MAX) m_err[op]++;
            m_flag = 1;
            if (!m_first_valid) begin
                m_first_valid = 1;
                m_first_op = op[1:0]; m_first_a = av[7:0]; m_first_b = bv[7:0]; m_first_y = yv[15:0];
            end
`ifdef ALU_CHECKER_HALT_EN
            m_halt = 1;
`endif
        end
    endtask

    function automatic logic [4*CNT_W-1:0] exp_errs();
        logic [CNT_W-1:0] e0, e1, e2, e3;
        e0 = m_err[0][CNT_W-1:0]; e1 = m_err[1][CNT_W-1:0];
        e2 = m_err[2][CNT_W-1:0]; e3 = m_err[3][CNT_W-1:0];
        return {e0, e1, e2, e3};
    endfunction

    function automatic logic [51:0] exp_stats();
        logic [15:0] s;
        s = m_samples[15:0];
        return {s, m_flag, m_first_valid, m_first_op, m_first_a, m_first_b, m_first_y};
    endfunction

    wire [4*CNT_W-1:0] act_errs  = {err_add, err_mul, err_dec, err_mov};
    wire [51:0]        act_stats = {sample_count, err_flag, first_valid, first_opcode,
                                    first_a, first_b, first_y};

    // Present one observation for one cycle; acc reports whether it was accepted.
    task automatic drive(input int op, input int av, input int bv, input int yv, output bit acc);
        @(negedge clk);
        opcode = op[1:0]; a = av[7:0]; b = bv[7:0]; y = yv[15:0]; in_valid = 1'b1;
        #1 acc = in_ready;
        @(posedge clk);
        if (acc) model_apply(op, av, bv, yv);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        checks++;
        if (act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL reset_outputs: got %h/%h want %h/%h", act_errs, act_stats, exp_errs(), exp_stats());
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add_stream();
        bit acc;
        int not_ready = 0;
        for (int i = 0; i < 20; i++) begin
            int av = (i == 0) ? 255 : $urandom_range(0, 255);
            int bv = (i == 0) ? 255 : $urandom_range(0, 255);
            drive(0, av, bv, av + bv, acc);
            if (!acc) not_ready++;
        end
        idle(3);
        checks++;
        if (not_ready !== 0) begin errors++; $display("FAIL add_ready_const: got %0d stalls want 0", not_ready); end
        checks++;
        if (sample_count !== 16'd20) begin errors++; $display("FAIL add_count: got %0d want 20", sample_count); end
        checks++;
        if (act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL add_stats: got %h/%h want %h/%h", act_errs, act_stats, exp_errs(), exp_stats());
        end
        do_clear();
    endtask

    task automatic test_directed();
        bit acc;
        drive(2, 0, 13, 16'hFFFF, acc);
        drive(1, 200, 150, 16'h7530, acc);
        drive(3, 9, 77, 16'h0004, acc);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err_mov !== '0) begin errors++; $display("FAIL mov_latency_early: got %0d want 0", err_mov); end
        @(negedge clk);
        checks++;
        if (err_mov !== CNT_W'(1) || first_opcode !== 2'd3 || first_y !== 16'h0004) begin
            errors++; $display("FAIL mov_capture: got %0d/%0d/%h want 1/3/0004", err_mov, first_opcode, first_y);
        end
        checks++;
        if (act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL directed_stats: got %h/%h want %h/%h", act_errs, act_stats, exp_errs(), exp_stats());
        end
        do_clear();
    endtask

    task automatic test_two_mismatch();
        bit acc, acc3;
        drive(1, 12, 11, 16'h0001, acc);
        drive(0, 40, 2, 16'h0002, acc);
        drive(3, 1, 5, 5, acc3);
        idle(3);
        checks++;
`ifdef ALU_CHECKER_HALT_EN
        if (acc3 !== 1'b0) begin errors++; $display("FAIL halt_ready: got %b want 0", acc3); end
`else
        if (acc3 !== 1'b1) begin errors++; $display("FAIL run_ready: got %b want 1", acc3); end
`endif
        checks++;
        if (act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL two_mis_stats: got %h/%h want %h/%h", act_errs, act_stats, exp_errs(), exp_stats());
        end
        checks++;
        if (first_opcode !== 2'd1 || first_a !== 8'd12 || first_b !== 8'd11) begin
            errors++; $display("FAIL two_mis_first: got %0d/%0d/%0d want 1/12/11", first_opcode, first_a, first_b);
        end
        do_clear();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_recover: got %b want 1", in_ready); end
    endtask

    task automatic test_saturation();
        bit acc;
        for (int i = 0; i < CNT_MAX + 6; i++) begin
            int av = $urandom_range(0, 255);
            int bv = $urandom_range(0, 255);
            drive(0, av, bv, (av + bv + 1 + $urandom_range(0, 100)) % 65536, acc);
        end
        idle(3);
        checks++;
        if (act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL saturation: got %h/%h want %h/%h", act_errs, act_stats, exp_errs(), exp_stats());
        end
        do_clear();
    endtask

    task automatic test_random();
        bit acc;
        for (int i = 0; i < 300; i++) begin
            int op = $urandom_range(0, 3);
            int av = $urandom_range(0, 255);
            int bv = $urandom_range(0, 255);
            int yv = ref_result(op, av, bv);
            if ($urandom_range(0, 9) == 0) yv = yv ^ $urandom_range(1, 65535);
            if ($urandom_range(0, 3) == 0) idle(0);
            drive(op, av, bv, yv, acc);
        end
        idle(3);
        checks++;
        if (act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL random_stats: got %h/%h want %h/%h", act_errs, act_stats, exp_errs(), exp_stats());
        end
        do_clear();
    endtask

    task automatic test_clear();
        bit acc;
        drive(2, 5, 0, 16'h0009, acc);
        drive(1, 3, 3, 16'h0000, acc);
        @(negedge clk);
        opcode = 2'd0; a = 8'd1; b = 8'd1; y = 16'h0000; in_valid = 1'b1; clear = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b want 0", in_ready); end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL clear_flush: got %h/%h want %h/%h", act_errs, act_stats, exp_errs(), exp_stats());
        end
    endtask

    task automatic test_rst_midstream();
        bit acc;
        drive(0, 1, 2, 7, acc);
        idle(3);
        checks++;
        if (err_add === '0) begin errors++; $display("FAIL pre_rst_count: got %0d want nonzero", err_add); end
        drive(1, 4, 4, 1, acc);
        drive(3, 4, 4, 2, acc);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (in_ready !== 1'b0 || act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL rst_mid: got %b %h/%h want 0 %h/%h", in_ready, act_errs, act_stats, exp_errs(), exp_stats());
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || act_errs !== exp_errs() || act_stats !== exp_stats()) begin
            errors++; $display("FAIL rst_after: got %b %h/%h want 1 %h/%h", in_ready, act_errs, act_stats, exp_errs(), exp_stats());
        end
    endtask

    initial begin
        test_reset();
        test_add_stream();
        test_directed();
        test_two_mismatch();
        test_saturation();
        test_random();
        test_clear();
        test_rst_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
